// File: rtl/sar_search_8.sv
// Successive-approximation searcher: recovers an unknown target by probing an external comparator.
// Optional feature: define SAR_EARLY_EXIT_EN to finish the search as soon as a verdict reports equality.
module sar_search_8 #(
   parameter int WIDTH = 8,
   localparam int CW = $clog2(WIDTH + 1),
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             guess_valid,
   output logic [WIDTH-1:0] guess,
   input  logic             cmp_valid,
   input  logic             cmp_gt,
   input  logic             cmp_eq,
   input  logic             cmp_lt,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result,
   output logic [CW-1:0]    probe_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PROBE,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] acc_q;
   logic [IW-1:0]    idx_q;

   logic [WIDTH-1:0] bit_mask_d;
   logic [WIDTH-1:0] next_mask_d;
   logic [WIDTH-1:0] acc_d;
   logic             one_hot_d;

   always_comb begin
      bit_mask_d  = WIDTH'(1) << idx_q;
      next_mask_d = bit_mask_d >> 1;
      one_hot_d   = $onehot({cmp_gt, cmp_eq, cmp_lt});
      // Without early exit, equality keeps the probed bit just like "greater".
      acc_d       = cmp_lt ? acc_q : (acc_q | bit_mask_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         idx_q       <= '0;
         busy        <= 1'b0;
         guess_valid <= 1'b0;
         guess       <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
         result      <= '0;
         probe_count <= '0;
      end else begin
         done <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  acc_q       <= '0;
                  idx_q       <= IW'(WIDTH - 1);
                  probe_count <= '0;
                  err         <= 1'b0;
                  guess       <= WIDTH'(1) << (WIDTH - 1);
                  guess_valid <= 1'b1;
                  busy        <= 1'b1;
                  state_q     <= S_PROBE;
               end
            end
            S_PROBE: begin
               if (cmp_valid) begin
                  probe_count <= probe_count + CW'(1);
                  if (!one_hot_d) begin
                     result      <= '0;
                     err         <= 1'b1;
                     guess_valid <= 1'b0;
                     done        <= 1'b1;
                     state_q     <= S_DONE;
                  end
`ifdef SAR_EARLY_EXIT_EN
                  else if (cmp_eq) begin
                     result      <= guess;
                     guess_valid <= 1'b0;
                     done        <= 1'b1;
                     state_q     <= S_DONE;
                  end
`endif
                  else if (idx_q == '0) begin
                     result      <= acc_d;
                     acc_q       <= acc_d;
                     guess_valid <= 1'b0;
                     done        <= 1'b1;
                     state_q     <= S_DONE;
                  end else begin
                     acc_q <= acc_d;
                     idx_q <= idx_q - IW'(1);
                     guess <= acc_d | next_mask_d;
                  end
               end
            end
            S_DONE: begin
               busy    <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
